// File: rtl/aes_pkg.sv
// Shared AES constants, FSM state type and GF(2^8) helpers
// used by the iterative inverse-cipher engine.
package aes_pkg;

  localparam int AES_BLK_W = 128;
  localparam int AES_KEY_W = 128;

  localparam logic [1:0] AES128 = 2'b00;
  localparam logic [1:0] AES192 = 2'b01;
  localparam logic [1:0] AES256 = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic logic [3:0] nr_of_mode(
    input logic [1:0] mode
  );
    case (mode)
      AES128:  return 4'd10;
      AES192:  return 4'd12;
      AES256:  return 4'd14;
      default: return 4'd10;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse; 0 maps to 0
  function automatic logic [7:0] gf_inv(
    input logic [7:0] x
  );
    logic [7:0] acc;
    logic [7:0] p;
    acc = 8'h01;
    p   = x;
    for (int i = 0; i < 7; i++) begin
      p   = gf_mul(p, p);
      acc = gf_mul(acc, p);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_inv_rounddata.sv
// Combinational single inverse AES round: key whitening on round 0,
// full inverse round in the middle, no InvMixColumns on the last.
module aes_inv_rounddata
  import aes_pkg::*;
(
  input  logic [3:0]           i_round,
  input  logic [1:0]           i_mode,
  input  logic [AES_KEY_W-1:0] i_key,
  input  logic [AES_BLK_W-1:0] i_data,
  output logic [AES_BLK_W-1:0] o_data
);

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] b
  );
    logic [7:0] a;
    a = {b[6:0], b[7]}
      ^ {b[4:0], b[7:5]}
      ^ {b[1:0], b[7:2]}
      ^ 8'h05;
    return gf_inv(a);
  endfunction

  // byte k of the block is row k%4, column k/4
  function automatic logic [127:0] inv_shsub(
    input logic [127:0] s
  );
    logic [127:0] o;
    int src;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        src = 4 * ((c - r + 4) % 4) + r;
        o[127-8*(4*c+r) -: 8] =
          inv_sbox(s[127-8*src -: 8]);
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_mix(
    input logic [127:0] s
  );
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] =
        gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
        ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] =
        gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
        ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] =
        gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
        ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] =
        gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
        ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  logic                 w_first;
  logic                 w_last;
  logic [AES_BLK_W-1:0] w_sr;

  assign w_first = (i_round == 4'd0);
  assign w_last  = (i_round == nr_of_mode(i_mode));
  assign w_sr    = inv_shsub(i_data) ^ i_key;

  always_comb begin
    o_data = '0;
    unique case (1'b1)
      w_first: o_data = i_data ^ i_key;
      w_last:  o_data = w_sr;
      default: o_data = inv_mix(w_sr);
    endcase
  end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES-128/192/256 decryption engine: one inverse round per
// clock, round keys streamed from an external key store, last first.
module aes_inv_round_ctrl
  import aes_pkg::*;
#(
  parameter bit CLEAR_ON_DONE = 1'b1,
  parameter int KEY_W         = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [KEY_W-1:0] in_data,
  output logic             rk_req,
  output logic [3:0]       rk_idx,
  input  logic [KEY_W-1:0] rk_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [KEY_W-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  state_e           r_st;
  state_e           w_st_nxt;
  logic [3:0]       r_round;
  logic [3:0]       w_round_nxt;
  logic [KEY_W-1:0] r_state;
  logic [KEY_W-1:0] w_state_nxt;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             r_err;
  logic             w_err_nxt;

  logic [3:0]       w_nr;
  logic [3:0]       w_in_nr;
  logic             w_legal;
  logic             w_accept;
  logic [KEY_W-1:0] w_round_out;

  aes_inv_rounddata u_round (
    .i_round (r_round),
    .i_mode  (r_mode),
    .i_key   (rk_data),
    .i_data  (r_state),
    .o_data  (w_round_out)
  );

  assign w_nr     = nr_of_mode(r_mode);
  assign w_in_nr  = nr_of_mode(in_mode);
  assign w_legal  = (in_mode != 2'b11);
  assign in_ready = (r_st == IDLE)
                  | ((r_st == DONE) & out_ready);
  assign w_accept = in_valid & in_ready;

  assign out_valid = (r_st == DONE);
  assign out_err   = r_err & (r_st == DONE);
  assign out_data  = r_state;
  assign busy      = (r_st != IDLE);

  always_comb begin
    w_st_nxt    = r_st;
    w_round_nxt = r_round;
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_err_nxt   = r_err;
    rk_req      = 1'b0;
    rk_idx      = 4'd0;
    unique case (r_st)
      RUN: begin
        w_state_nxt = w_round_out;
        if (r_round < w_nr) begin
          rk_req      = 1'b1;
          rk_idx      = w_nr - r_round - 4'd1;
          w_round_nxt = r_round + 4'd1;
        end else begin
          w_st_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_st_nxt = IDLE;
          if (CLEAR_ON_DONE) w_state_nxt = '0;
        end
      end
      default: ;
    endcase
    // acceptance overrides the DONE release when both coincide
    if (w_accept) begin
      w_state_nxt = in_data;
      w_mode_nxt  = in_mode;
      w_round_nxt = 4'd0;
      w_err_nxt   = ~w_legal;
      if (w_legal) begin
        rk_req   = 1'b1;
        rk_idx   = w_in_nr;
        w_st_nxt = RUN;
      end else begin
        w_st_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_round <= 4'd0;
      r_state <= '0;
      r_mode  <= 2'b00;
      r_err   <= 1'b0;
    end else begin
      r_st    <= w_st_nxt;
      r_round <= w_round_nxt;
      r_state <= w_state_nxt;
      r_mode  <= w_mode_nxt;
      r_err   <= w_err_nxt;
    end
  end

  a_round: assert property (
    @(posedge clk) disable iff (!rst_n)
    (r_round <= 4'd14)
    && (r_st != RUN || r_round <= w_nr)
  );

  a_idx: assert property (
    @(posedge clk) disable iff (!rst_n)
    !rk_req || rk_idx <= (w_accept ? w_in_nr : w_nr)
  );

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: FIPS-197 vectors, backpressure,
// illegal mode, async reset and random blocks against a table model.
module tb_aes_inv_round_ctrl;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_mode;
  logic [127:0] in_data;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic [127:0] rk_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_err;
  logic         busy;

  logic         k_in_ready;
  logic         k_rk_req;
  logic [3:0]   k_rk_idx;
  logic         k_out_valid;
  logic [127:0] k_out_data;
  logic         k_out_err;
  logic         k_busy;

  int total = 0;
  int bad   = 0;

  logic [127:0] ks [0:14];
  logic [7:0]   sb [256];
  logic [7:0]   isb [256];
  logic [3:0]   rkq [$];

  aes_inv_round_ctrl #(.CLEAR_ON_DONE(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_data(in_data),
    .rk_req(rk_req), .rk_idx(rk_idx), .rk_data(rk_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  aes_inv_round_ctrl #(.CLEAR_ON_DONE(1'b0)) dut_k (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(k_in_ready),
    .in_mode(in_mode), .in_data(in_data),
    .rk_req(k_rk_req), .rk_idx(k_rk_idx), .rk_data(rk_data),
    .out_valid(k_out_valid), .out_ready(out_ready),
    .out_data(k_out_data), .out_err(k_out_err), .busy(k_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // key store: data for the requested index one cycle later, junk otherwise
  always @(posedge clk) begin
    if (rk_req) begin
      rk_data <= ks[rk_idx];
      rkq.push_back(rk_idx);
    end else begin
      rk_data <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mulc(input logic [7:0] a,
                                      input int c);
    logic [7:0] x2, x4, x8;
    x2 = xt(a);
    x4 = xt(x2);
    x8 = xt(x4);
    case (c)
      9:       return x8 ^ a;
      11:      return x8 ^ x2 ^ a;
      13:      return x8 ^ x4 ^ a;
      default: return x8 ^ x4 ^ x2;
    endcase
  endfunction

  task automatic init_tables();
    logic [2047:0] t;
    t = {128'h637c777bf26b6fc53001672bfed7ab76,
         128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115,
         128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84,
         128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8,
         128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973,
         128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479,
         128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
         128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df,
         128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sb[i] = t[2047-8*i -: 8];
    for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic expand(input logic [255:0] key, input int nk);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rc;
    int          nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4 * (nr + 1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int j = 0; j < 15; j++) ks[j] = '0;
    for (int j = 0; j <= nr; j++)
      ks[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  function automatic logic [127:0] decrypt(input logic [127:0] ct,
                                           input int nr);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] o;
    k = ks[nr];
    for (int i = 0; i < 16; i++)
      s[i] = ct[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int rd = nr - 1; rd >= 0; rd--) begin
      k = ks[rd];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = isb[s[4*((c-r+4)%4)+r]]
                   ^ k[127-8*(4*c+r) -: 8];
      for (int c = 0; c < 4; c++) begin
        if (rd > 0) begin
          s[4*c+0] = mulc(t[4*c], 14) ^ mulc(t[4*c+1], 11)
                   ^ mulc(t[4*c+2], 13) ^ mulc(t[4*c+3], 9);
          s[4*c+1] = mulc(t[4*c], 9) ^ mulc(t[4*c+1], 14)
                   ^ mulc(t[4*c+2], 11) ^ mulc(t[4*c+3], 13);
          s[4*c+2] = mulc(t[4*c], 13) ^ mulc(t[4*c+1], 9)
                   ^ mulc(t[4*c+2], 14) ^ mulc(t[4*c+3], 11);
          s[4*c+3] = mulc(t[4*c], 11) ^ mulc(t[4*c+1], 13)
                   ^ mulc(t[4*c+2], 9) ^ mulc(t[4*c+3], 14);
        end else begin
          for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
        end
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  task automatic offer(input logic [127:0] ct,
                       input logic [1:0] md,
                       input logic rdy,
                       input string tag);
    rkq.delete();
    in_valid  = 1'b1;
    in_data   = ct;
    in_mode   = md;
    out_ready = rdy;
    #1;
    chk({tag, "_in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = {$urandom, $urandom, $urandom, $urandom};
    in_mode   = 2'($urandom);
  endtask

  task automatic collect(input logic [127:0] exp,
                         input logic err,
                         input int lat,
                         input int nr,
                         input string tag);
    int k;
    logic ok;
    k = 1;
    while (out_valid !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, k, lat);
    chk({tag, "_data"}, out_data, exp);
    chk({tag, "_err"}, out_err, err);
    chk({tag, "_busy"}, busy, 1);
    ok = (rkq.size() == (err ? 0 : nr + 1));
    if (ok && !err)
      for (int i = 0; i <= nr; i++)
        if (rkq[i] != 4'(nr - i)) ok = 1'b0;
    chk({tag, "_rk_seq"}, ok, 1);
  endtask

  task automatic hold(input int n, input logic [127:0] exp,
                      input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, out_valid, 1);
      chk({tag, "_hold_data"}, out_data, exp);
      chk({tag, "_hold_in_ready"}, in_ready, 0);
      chk({tag, "_hold_busy"}, busy, 1);
    end
  endtask

  task automatic release_out(input logic [127:0] exp_k,
                             input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_rel_valid"}, out_valid, 0);
    chk({tag, "_rel_busy"}, busy, 0);
    chk({tag, "_clear_state"}, dut.r_state, 0);
    chk({tag, "_keep_state"}, dut_k.r_state, exp_k);
  endtask

  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT3  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] K128 =
    {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K192 =
    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  initial begin
    logic [127:0] ct;
    logic [127:0] exp;
    logic [255:0] key;
    int           md;
    int           nr;

    init_tables();
    for (int j = 0; j < 15; j++) ks[j] = '0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_mode   = 2'b00;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_rk_req", rk_req, 0);
    chk("rst_rk_idx", rk_idx, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_state", dut.r_state, 0);

    expand(K128, 4);
    offer(CT1, 2'b00, 1'b0, "c1");
    collect(PT, 1'b0, 12, 10, "c1");
    hold(5, PT, "c1");
    ct  = {$urandom, $urandom, $urandom, $urandom};
    exp = decrypt(ct, 10);
    offer(ct, 2'b00, 1'b1, "b2b");
    collect(exp, 1'b0, 12, 10, "b2b");
    release_out(exp, "b2b");

    expand(K192, 6);
    offer(CT2, 2'b01, 1'b0, "c2");
    collect(PT, 1'b0, 14, 12, "c2");
    release_out(PT, "c2");

    expand(K256, 8);
    offer(CT3, 2'b10, 1'b0, "c3");
    collect(PT, 1'b0, 16, 14, "c3");
    release_out(PT, "c3");

    offer({16{8'ha5}}, 2'b11, 1'b0, "ill");
    collect({16{8'ha5}}, 1'b1, 1, 0, "ill");
    release_out({16{8'ha5}}, "ill");

    offer(CT3, 2'b10, 1'b0, "rst");
    repeat (5) @(negedge clk);
    chk("rst_pre_busy", busy, 1);
    chk("rst_pre_rk_req", rk_req, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_rk_req", rk_req, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_in_ready", in_ready, 1);
    #7 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_state", dut.r_state, 0);
    expand(K128, 4);
    offer(CT1, 2'b00, 1'b0, "c1b");
    collect(PT, 1'b0, 12, 10, "c1b");
    release_out(PT, "c1b");

    for (int it = 0; it < 4; it++) begin
      md  = int'($urandom_range(0, 2));
      nr  = 10 + 2 * md;
      key = {$urandom, $urandom, $urandom, $urandom,
             $urandom, $urandom, $urandom, $urandom};
      expand(key, 4 + 2 * md);
      ct  = {$urandom, $urandom, $urandom, $urandom};
      exp = decrypt(ct, nr);
      offer(ct, 2'(md), 1'b0, "rnd");
      collect(exp, 1'b0, nr + 2, nr, "rnd");
      hold(int'($urandom_range(0, 2)), exp, "rnd");
      release_out(exp, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
